// File: rtl/arlet6502_core.sv
// Reduced 6502-compatible core: reset-vector fetch plus LDA/ADC/STA/JMP/CLC/SEC/NOP,
// running against a synchronous memory whose read data arrives one cycle after its address.
module arlet6502_core #(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
  input  logic        r_Clk,
  input  logic        RST,
  output logic [15:0] A,
  input  logic [7:0]  DI,
  output logic [7:0]  DO,
  output logic        WE,
  input  logic        IRQ,
  input  logic        NMI,
  input  logic        RDY
);

  typedef enum logic [3:0] {
    ST_VEC0, ST_VEC1, ST_VEC2, ST_FETCH, ST_DECODE,
    ST_IMPL, ST_IMM, ST_ABS0, ST_ABS1, ST_LOADV
  } state_t;

  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_ADC_IMM = 8'h69;
  localparam logic [7:0] OP_LDA_ABS = 8'hAD;
  localparam logic [7:0] OP_STA_ABS = 8'h8D;
  localparam logic [7:0] OP_JMP_ABS = 8'h4C;
  localparam logic [7:0] OP_CLC     = 8'h18;
  localparam logic [7:0] OP_SEC     = 8'h38;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  adl_q, adl_d;
  logic        n_q, n_d, v_q, v_d, z_q, z_d, c_q, c_d;
  logic        weRaw;
  logic [8:0]  adcSum;
  logic        unusedIrqNmi;

  // Interrupt inputs are reserved for a later revision.
  assign unusedIrqNmi = IRQ & NMI;

  assign adcSum = {1'b0, acc_q} + {1'b0, DI} + {8'd0, c_q};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    ir_d    = ir_q;
    adl_d   = adl_q;
    n_d     = n_q;
    v_d     = v_q;
    z_d     = z_q;
    c_d     = c_q;
    A       = pc_q;
    weRaw   = 1'b0;
    case (state_q)
      ST_VEC0: begin
        A       = RESET_VECTOR;
        state_d = ST_VEC1;
      end
      ST_VEC1: begin
        A       = RESET_VECTOR + 16'd1;
        pc_d    = {pc_q[15:8], DI};
        state_d = ST_VEC2;
      end
      ST_VEC2: begin
        A       = {DI, pc_q[7:0]};
        pc_d    = {DI, pc_q[7:0]} + 16'd1;
        state_d = ST_DECODE;
      end
      ST_FETCH: begin
        pc_d    = pc_q + 16'd1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        // The opcode is still on DI here, so branch on DI rather than IR.
        ir_d = DI;
        case (DI)
          OP_LDA_IMM, OP_ADC_IMM: begin
            pc_d    = pc_q + 16'd1;
            state_d = ST_IMM;
          end
          OP_LDA_ABS, OP_STA_ABS, OP_JMP_ABS: begin
            pc_d    = pc_q + 16'd1;
            state_d = ST_ABS0;
          end
          default: state_d = ST_IMPL;
        endcase
      end
      ST_IMPL: begin
        if (ir_q == OP_CLC) begin
          c_d = 1'b0;
        end else if (ir_q == OP_SEC) begin
          c_d = 1'b1;
        end
        pc_d    = pc_q + 16'd1;
        state_d = ST_DECODE;
      end
      ST_IMM: begin
        if (ir_q == OP_LDA_IMM) begin
          acc_d = DI;
          n_d   = DI[7];
          z_d   = (DI == 8'h00);
        end else begin
          acc_d = adcSum[7:0];
          c_d   = adcSum[8];
          v_d   = (acc_q[7] == DI[7]) && (adcSum[7] != acc_q[7]);
          n_d   = adcSum[7];
          z_d   = (adcSum[7:0] == 8'h00);
        end
        pc_d    = pc_q + 16'd1;
        state_d = ST_DECODE;
      end
      ST_ABS0: begin
        adl_d   = DI;
        pc_d    = pc_q + 16'd1;
        state_d = ST_ABS1;
      end
      ST_ABS1: begin
        A = {DI, adl_q};
        case (ir_q)
          OP_JMP_ABS: begin
            pc_d    = {DI, adl_q} + 16'd1;
            state_d = ST_DECODE;
          end
          OP_STA_ABS: begin
            weRaw   = 1'b1;
            state_d = ST_FETCH;
          end
          default: state_d = ST_LOADV;
        endcase
      end
      ST_LOADV: begin
        acc_d   = DI;
        n_d     = DI[7];
        z_d     = (DI == 8'h00);
        pc_d    = pc_q + 16'd1;
        state_d = ST_DECODE;
      end
      default: state_d = ST_VEC0;
    endcase
  end

  assign WE = weRaw & RDY;
  assign DO = acc_q;

  // Reset wins over RDY; a stall freezes every register so execution resumes in place.
  always_ff @(posedge r_Clk) begin
    if (!RST) begin
      state_q <= ST_VEC0;
      pc_q    <= 16'h0000;
      acc_q   <= 8'h00;
      ir_q    <= 8'h00;
      adl_q   <= 8'h00;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else if (RDY) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ir_q    <= ir_d;
      adl_q   <= adl_d;
      n_q     <= n_d;
      v_q     <= v_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

endmodule

// File: tb/tb_arlet6502_core.sv
// Bench for arlet6502_core: directed boot/stall/reset scenarios plus random programs,
// checked against an instruction-level model of bus writes and their cycle numbers.
module tb_arlet6502_core;

  logic        r_Clk = 1'b0;
  logic        RST = 1'b0;
  logic        RDY = 1'b1;
  logic        IRQ = 1'b1;
  logic        NMI = 1'b1;
  logic [15:0] A;
  logic [7:0]  DI;
  logic [7:0]  DO;
  logic        WE;

  int checks = 0;
  int errors = 0;
  int rawCyc = 0;
  int actCyc = 0;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
    int          raw;
  } wr_t;

  wr_t obsQ[$];
  wr_t expQ[$];
  logic [7:0] mem [0:65535];
  logic [7:0] refMem [0:65535];
  logic [7:0] prog[$];

  always #5 r_Clk = ~r_Clk;

  arlet6502_core #(.RESET_VECTOR(16'hFFFC)) dut (
    .r_Clk(r_Clk), .RST(RST), .A(A), .DI(DI), .DO(DO), .WE(WE),
    .IRQ(IRQ), .NMI(NMI), .RDY(RDY)
  );

  // Synchronous memory; DI is held while the core is stalled.
  always @(posedge r_Clk) begin
    if (WE === 1'b1) mem[A] <= DO;
    if (RDY) DI <= mem[A];
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // One bus cycle: inputs change just after the rising edge, outputs are sampled at the falling edge.
  task automatic applyStimulus(input logic rstV, input logic rdyV);
    wr_t w;
    @(posedge r_Clk);
    #1;
    RST = rstV;
    RDY = rdyV;
    @(negedge r_Clk);
    if (!rstV) begin
      rawCyc = 0;
      actCyc = 0;
      obsQ.delete();
    end else begin
      rawCyc++;
      if (rdyV) actCyc++;
      if (WE === 1'b1) begin
        w.addr = A; w.data = DO; w.cyc = actCyc; w.raw = rawCyc;
        obsQ.push_back(w);
      end
    end
  endtask

  task automatic clearMem();
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'h00;
      refMem[i] = 8'h00;
    end
    mem[16'hFFFC] = 8'h00; refMem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h80; refMem[16'hFFFD] = 8'h80;
  endtask

  task automatic loadProg(input logic [15:0] base);
    for (int i = 0; i < prog.size(); i++) begin
      mem[base + 16'(i)] = prog[i];
      refMem[base + 16'(i)] = prog[i];
    end
  endtask

  task automatic loadCounterProg();
    clearMem();
    prog = '{8'hA9, 8'h06, 8'h69, 8'h07, 8'h8D, 8'h00, 8'hE2, 8'h4C, 8'h0A, 8'h24};
    loadProg(16'h8000);
    prog = '{8'hAD, 8'h00, 8'hE2, 8'h69, 8'h01, 8'h8D, 8'h00, 8'hE2, 8'h4C, 8'h0A, 8'h24};
    loadProg(16'h240A);
  endtask

  task automatic runActive(input int limit, input int stallPct);
    logic rdyV;
    while (actCyc < limit && rawCyc < limit * 5 + 100) begin
      rdyV = ($urandom_range(99) >= stallPct) ? 1'b1 : 1'b0;
      applyStimulus(1'b1, rdyV);
    end
    checkOutput("run_bound", actCyc, limit);
  endtask

  // Instruction-level reference: walks the program and lists each store with the
  // unstalled cycle it lands in (vector takes 3 cycles, first opcode is cycle 4).
  task automatic modelRun(input int limit);
    logic [15:0] pc, ea;
    logic [7:0]  acc, op, imm;
    logic        c;
    logic [8:0]  s;
    int          t;
    wr_t         w;
    expQ.delete();
    pc  = {refMem[16'hFFFD], refMem[16'hFFFC]};
    acc = 8'h00;
    c   = 1'b0;
    t   = 4;
    while (t <= limit) begin
      op  = refMem[pc];
      imm = refMem[pc + 16'd1];
      ea  = {refMem[pc + 16'd2], refMem[pc + 16'd1]};
      case (op)
        8'hA9: begin acc = imm; pc = pc + 16'd2; t += 2; end
        8'h69: begin
          s   = {1'b0, acc} + {1'b0, imm} + {8'd0, c};
          acc = s[7:0];
          c   = s[8];
          pc  = pc + 16'd2;
          t  += 2;
        end
        8'hAD: begin acc = refMem[ea]; pc = pc + 16'd3; t += 4; end
        8'h8D: begin
          if (t + 2 <= limit) begin
            w.addr = ea; w.data = acc; w.cyc = t + 2; w.raw = 0;
            expQ.push_back(w);
          end
          refMem[ea] = acc;
          pc = pc + 16'd3;
          t += 4;
        end
        8'h4C: begin pc = ea; t += 3; end
        8'h18: begin c = 1'b0; pc = pc + 16'd1; t += 2; end
        8'h38: begin c = 1'b1; pc = pc + 16'd1; t += 2; end
        default: begin pc = pc + 16'd1; t += 2; end
      endcase
    end
  endtask

  task automatic compareWrites(input string tag);
    int n;
    checkOutput({tag, "_count"}, obsQ.size(), expQ.size());
    n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_addr%0d", tag, i), obsQ[i].addr, expQ[i].addr);
      checkOutput($sformatf("%s_data%0d", tag, i), obsQ[i].data, expQ[i].data);
      checkOutput($sformatf("%s_cyc%0d", tag, i), obsQ[i].cyc, expQ[i].cyc);
    end
  endtask

  initial begin
    logic [15:0] bootAddr [4];
    logic [7:0]  kind;
    logic [15:0] pcGen;
    bootAddr = '{16'hFFFC, 16'hFFFD, 16'h8000, 16'h8001};

    // Reset hold, boot sequence, straight-line store and the counter loop.
    loadCounterProg();
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b0, 1'b1);
      if (k >= 2) begin
        checkOutput("rst_hold_A", A, 16'hFFFC);
        checkOutput("rst_hold_WE", WE, 1'b0);
        checkOutput("rst_hold_DO", DO, 8'h00);
      end
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b1);
      checkOutput($sformatf("boot_A%0d", k), A, bootAddr[k]);
    end
    runActive(80, 0);
    modelRun(80);
    compareWrites("loop");
    checkOutput("first_wr_addr", obsQ[0].addr, 16'hE200);
    checkOutput("first_wr_data", obsQ[0].data, 8'h0D);
    checkOutput("first_wr_cyc", obsQ[0].cyc, 10);
    checkOutput("second_wr_data", obsQ[1].data, 8'h0E);
    checkOutput("third_wr_data", obsQ[2].data, 8'h0F);
    checkOutput("wr_spacing", obsQ[2].cyc - obsQ[1].cyc, 13);

    // Five-cycle stall starting just after cycle 9.
    loadCounterProg();
    repeat (2) applyStimulus(1'b0, 1'b1);
    repeat (9) applyStimulus(1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("stall_A", A, 16'hE200);
      checkOutput("stall_DO", DO, 8'h0D);
      checkOutput("stall_WE", WE, 1'b0);
    end
    runActive(80, 0);
    modelRun(80);
    compareWrites("stall");
    checkOutput("stall_first_raw", obsQ[0].raw, 15);
    checkOutput("stall_second_raw", obsQ[1].raw, 28);

    // Carry and overflow chain.
    clearMem();
    prog = '{8'hA9, 8'h7F, 8'h69, 8'h01, 8'h8D, 8'h01, 8'hE2, 8'h69, 8'h80,
             8'h8D, 8'h02, 8'hE2, 8'h69, 8'h00, 8'h8D, 8'h03, 8'hE2, 8'h18,
             8'h69, 8'h00, 8'h8D, 8'h04, 8'hE2, 8'h4C, 8'h17, 8'h80};
    loadProg(16'h8000);
    repeat (2) applyStimulus(1'b0, 1'b1);
    runActive(60, 0);
    modelRun(60);
    compareWrites("carry");
    checkOutput("carry_w1", {obsQ[0].addr, obsQ[0].data}, 24'hE20180);
    checkOutput("carry_w2", {obsQ[1].addr, obsQ[1].data}, 24'hE20200);
    checkOutput("carry_w3", {obsQ[2].addr, obsQ[2].data}, 24'hE20301);
    checkOutput("carry_w4", {obsQ[3].addr, obsQ[3].data}, 24'hE20401);

    // Reset asserted during the store cycle of STA.
    loadCounterProg();
    repeat (2) applyStimulus(1'b0, 1'b1);
    repeat (9) applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("midrst_A", A, 16'hFFFC);
    checkOutput("midrst_WE", WE, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("midrst_A2", A, 16'hFFFD);
    runActive(30, 0);
    modelRun(30);
    compareWrites("midrst");

    // Random programs with random stalls.
    for (int it = 0; it < 3; it++) begin
      clearMem();
      for (int i = 0; i < 256; i++) begin
        mem[16'hD000 + 16'(i)] = 8'($urandom);
        refMem[16'hD000 + 16'(i)] = mem[16'hD000 + 16'(i)];
      end
      prog.delete();
      for (int i = 0; i < 24; i++) begin
        kind = 8'($urandom_range(7));
        case (kind)
          8'd0: prog = {prog, 8'hA9, 8'($urandom)};
          8'd1, 8'd2: prog = {prog, 8'h69, 8'($urandom)};
          8'd3: prog = {prog, 8'h18};
          8'd4: prog = {prog, 8'h38};
          8'd5: prog = {prog, 8'hEA};
          8'd6: prog = {prog, 8'h8D, 8'($urandom_range(15)), 8'hE2};
          default: prog = {prog, 8'hAD, 8'($urandom_range(15)),
                           ($urandom_range(1) == 1) ? 8'hE2 : 8'hD0};
        endcase
      end
      prog = {prog, 8'h8D, 8'h0F, 8'hE2};
      pcGen = 16'h8000 + 16'(prog.size());
      prog = {prog, 8'h4C, pcGen[7:0], pcGen[15:8]};
      loadProg(16'h8000);
      repeat (2) applyStimulus(1'b0, 1'b1);
      runActive(250, 25);
      modelRun(250);
      compareWrites($sformatf("rand%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
